// File: rtl/boot_ctrl_pkg.sv
// rtl/boot_ctrl_pkg.sv - shared types and default constants for the boot sequencer
package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SPI  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  localparam logic [31:0] CFG_ADDR_DEF      = 32'h1A10_7008;
  localparam logic [31:0] BOOT_ADDR_RST_DEF = 32'h0000_8000;

endpackage

// File: rtl/boot_ctrl_arb.sv
// rtl/boot_ctrl_arb.sv - 2-way fixed-priority (debug first) burst-lock write arbiter
module boot_ctrl_arb
  import boot_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   block_i,
  input  logic   spi_req_i,
  input  logic   spi_last_i,
  input  logic   dbg_req_i,
  input  logic   dbg_last_i,
  input  logic   accept_i,
  output logic   sel_spi_o,
  output logic   sel_dbg_o,
  output owner_e owner_o
);

  owner_e owner_q, owner_d;

  always_comb begin
    sel_spi_o = 1'b0;
    sel_dbg_o = 1'b0;
    if (!block_i) begin
      case (owner_q)
        OWN_SPI: sel_spi_o = spi_req_i;
        OWN_DBG: sel_dbg_o = dbg_req_i;
        default: begin
          sel_dbg_o = dbg_req_i;
          sel_spi_o = spi_req_i && !dbg_req_i;
        end
      endcase
    end
  end

  // Ownership is taken on the first accepted beat and released on the accepted last beat.
  always_comb begin
    owner_d = owner_q;
    if (accept_i) begin
      if (sel_dbg_o) begin
        owner_d = dbg_last_i ? OWN_NONE : OWN_DBG;
      end else if (sel_spi_o) begin
        owner_d = spi_last_i ? OWN_NONE : OWN_SPI;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - boot sequencer: shares the memory write port, intercepts the
// boot-address register and releases core fetch enable after load plus settle delay
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH    = 32,
  parameter int unsigned             DATA_WIDTH    = 32,
  parameter int unsigned             HOLD_CYCLES   = 16,
  parameter logic [ADDR_WIDTH-1:0]   BOOT_ADDR_RST = BOOT_ADDR_RST_DEF,
  parameter logic [ADDR_WIDTH-1:0]   CFG_ADDR      = CFG_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_req_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [DATA_WIDTH-1:0] spi_wdata_i,
  input  logic                  spi_last_i,
  output logic                  spi_gnt_o,
  input  logic                  dbg_req_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  input  logic                  dbg_last_i,
  output logic                  dbg_gnt_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  fetch_enable_i,
  output logic                  fetch_enable_o,
  output logic [ADDR_WIDTH-1:0] boot_addr_o,
  output logic [2:0]            state_o,
  output logic [15:0]           wr_count_o
);

  localparam logic [15:0] HOLD_LD = 16'(HOLD_CYCLES);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  fetch_en_q, fetch_en_d;
  logic [ADDR_WIDTH-1:0] boot_addr_q, boot_addr_d;
  logic [15:0]           wr_count_q, wr_count_d;

  logic                  sel_spi, sel_dbg, valid, is_cfg, accept, fwd_accept, load_done;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  owner_e                owner;

  // Reset also blocks grants so a beat presented during reset is never acknowledged.
  boot_ctrl_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .block_i    ((state_q == ST_HOLD) || rst),
    .spi_req_i  (spi_req_i),
    .spi_last_i (spi_last_i),
    .dbg_req_i  (dbg_req_i),
    .dbg_last_i (dbg_last_i),
    .accept_i   (accept),
    .sel_spi_o  (sel_spi),
    .sel_dbg_o  (sel_dbg),
    .owner_o    (owner)
  );

  always_comb begin
    sel_addr   = sel_dbg ? dbg_addr_i  : spi_addr_i;
    sel_wdata  = sel_dbg ? dbg_wdata_i : spi_wdata_i;
    valid      = sel_spi || sel_dbg;
    is_cfg     = valid && (sel_addr == CFG_ADDR);
    mem_req_o  = valid && !is_cfg;
    fwd_accept = mem_req_o && mem_gnt_i;
    accept     = is_cfg || fwd_accept;
    load_done  = fetch_enable_i && (owner == OWN_NONE) && !spi_req_i && !dbg_req_i;
  end

  assign mem_addr_o  = sel_addr;
  assign mem_wdata_o = sel_wdata;
  assign spi_gnt_o   = accept && sel_spi;
  assign dbg_gnt_o   = accept && sel_dbg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (load_done) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else if (accept) begin
          state_d = ST_LOAD;
        end
      end
      ST_HOLD: begin
        // A counter of 0 or 1 ends HOLD this cycle, so HOLD_CYCLES=0 still spends one cycle here.
        if (!fetch_enable_i) begin
          state_d = ST_LOAD;
        end else if (cnt_q <= 16'd1) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    fetch_en_d = (state_d == ST_RUN);
  end

  always_comb begin
    boot_addr_d = boot_addr_q;
    if (is_cfg && state_q != ST_RUN) begin
      boot_addr_d = sel_wdata[ADDR_WIDTH-1:0];
    end
    wr_count_d = wr_count_q;
    if (fwd_accept && wr_count_q != 16'hFFFF) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      fetch_en_q  <= 1'b0;
      boot_addr_q <= BOOT_ADDR_RST;
      wr_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fetch_en_q  <= fetch_en_d;
      boot_addr_q <= boot_addr_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign fetch_enable_o = fetch_en_q;
  assign boot_addr_o    = boot_addr_q;
  assign state_o        = state_q;
  assign wr_count_o     = wr_count_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// tb/tb_boot_ctrl.sv - directed self-checking bench for boot_ctrl
module tb_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_req_i, spi_last_i, dbg_req_i, dbg_last_i;
  logic [31:0] spi_addr_i, spi_wdata_i, dbg_addr_i, dbg_wdata_i;
  logic        spi_gnt_o, dbg_gnt_o, mem_req_o, mem_gnt_i;
  logic [31:0] mem_addr_o, mem_wdata_o, boot_addr_o;
  logic        fetch_enable_i, fetch_enable_o;
  logic [2:0]  state_o;
  logic [15:0] wr_count_o;

  int n_chk  = 0;
  int n_fail = 0;

  boot_ctrl dut (
    .clk(clk), .rst(rst),
    .spi_req_i(spi_req_i), .spi_addr_i(spi_addr_i), .spi_wdata_i(spi_wdata_i),
    .spi_last_i(spi_last_i), .spi_gnt_o(spi_gnt_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_last_i(dbg_last_i), .dbg_gnt_o(dbg_gnt_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .fetch_enable_i(fetch_enable_i), .fetch_enable_o(fetch_enable_o),
    .boot_addr_o(boot_addr_o), .state_o(state_o), .wr_count_o(wr_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    spi_req_i = 0; spi_last_i = 0; spi_addr_i = 0; spi_wdata_i = 0;
    dbg_req_i = 0; dbg_last_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
  endtask

  task automatic drive_spi(input logic [31:0] a, input logic [31:0] d, input logic l);
    spi_req_i = 1; spi_addr_i = a; spi_wdata_i = d; spi_last_i = l;
  endtask

  task automatic drive_dbg(input logic [31:0] a, input logic [31:0] d, input logic l);
    dbg_req_i = 1; dbg_addr_i = a; dbg_wdata_i = d; dbg_last_i = l;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); mem_gnt_i = 1; fetch_enable_i = 0;
    tick(); tick();
    rst = 0;
    #1;
    n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_o); end
    n_chk++; if (fetch_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_fetch got %b exp 0", fetch_enable_o); end
    n_chk++; if (boot_addr_o !== 32'h0000_8000) begin n_fail++; $display("FAIL reset_boot_addr got %h exp 00008000", boot_addr_o); end
    n_chk++; if (wr_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d exp 0", wr_count_o); end
    n_chk++; if (mem_req_o !== 1'b0 || spi_gnt_o !== 1'b0 || dbg_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_gnt got req=%b sg=%b dg=%b exp 0", mem_req_o, spi_gnt_o, dbg_gnt_o);
    end
  endtask

  task automatic test_spi_burst();
    for (int i = 0; i < 8; i++) begin
      drive_spi(32'(i * 4), 32'hA0 + 32'(i), i == 7);
      #1;
      n_chk++; if (spi_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'(i * 4) || mem_wdata_o !== 32'hA0 + 32'(i)) begin
        n_fail++; $display("FAIL spi_beat %0d got gnt=%b req=%b addr=%h data=%h exp 1 1 %h %h",
                           i, spi_gnt_o, mem_req_o, mem_addr_o, mem_wdata_o, i * 4, 32'hA0 + i);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_chk++; if (wr_count_o !== 16'd8) begin n_fail++; $display("FAIL spi_wr_count got %0d exp 8", wr_count_o); end
    n_chk++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL spi_state got %0d exp 1", state_o); end
  endtask

  task automatic test_cfg_write();
    drive_dbg(32'h1A10_7008, 32'h0, 1'b1);
    #1;
    n_chk++; if (dbg_gnt_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL cfg_gnt got dg=%b req=%b exp 1 0", dbg_gnt_o, mem_req_o);
    end
    tick();
    idle_inputs();
    #1;
    n_chk++; if (boot_addr_o !== 32'h0) begin n_fail++; $display("FAIL cfg_boot_addr got %h exp 00000000", boot_addr_o); end
    n_chk++; if (wr_count_o !== 16'd8) begin n_fail++; $display("FAIL cfg_wr_count got %0d exp 8", wr_count_o); end
  endtask

  task automatic test_simultaneous();
    drive_spi(32'h200, 32'h5A5A, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_dbg(32'h100 + 32'(i * 4), 32'hD0 + 32'(i), i == 3);
      #1;
      n_chk++; if (dbg_gnt_o !== 1'b1 || spi_gnt_o !== 1'b0 || mem_addr_o !== 32'h100 + 32'(i * 4)) begin
        n_fail++; $display("FAIL simul_dbg_beat %0d got dg=%b sg=%b addr=%h exp 1 0 %h",
                           i, dbg_gnt_o, spi_gnt_o, mem_addr_o, 32'h100 + i * 4);
      end
      tick();
    end
    dbg_req_i = 0;
    #1;
    n_chk++; if (spi_gnt_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL simul_spi_after got sg=%b addr=%h exp 1 00000200", spi_gnt_o, mem_addr_o);
    end
    tick();
    idle_inputs();
    #1;
    n_chk++; if (wr_count_o !== 16'd13) begin n_fail++; $display("FAIL simul_wr_count got %0d exp 13", wr_count_o); end
  endtask

  task automatic test_backpressure();
    drive_spi(32'h300, 32'h1, 1'b0);
    #1;
    n_chk++; if (spi_gnt_o !== 1'b1) begin n_fail++; $display("FAIL bp_beat0 got %b exp 1", spi_gnt_o); end
    tick();
    drive_spi(32'h304, 32'h2, 1'b0);
    drive_dbg(32'h400, 32'h9, 1'b1);
    mem_gnt_i = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (spi_gnt_o !== 1'b0 || dbg_gnt_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h304 || mem_wdata_o !== 32'h2) begin
        n_fail++; $display("FAIL bp_stall %0d got sg=%b dg=%b req=%b addr=%h data=%h exp 0 0 1 00000304 00000002",
                           i, spi_gnt_o, dbg_gnt_o, mem_req_o, mem_addr_o, mem_wdata_o);
      end
      n_chk++; if (wr_count_o !== 16'd14) begin n_fail++; $display("FAIL bp_stall_count %0d got %0d exp 14", i, wr_count_o); end
      tick();
    end
    mem_gnt_i = 1;
    #1;
    n_chk++; if (spi_gnt_o !== 1'b1 || dbg_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_resume got sg=%b dg=%b exp 1 0", spi_gnt_o, dbg_gnt_o);
    end
    tick();
    drive_spi(32'h308, 32'h3, 1'b1);
    #1;
    n_chk++; if (spi_gnt_o !== 1'b1 || dbg_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_last got sg=%b dg=%b exp 1 0", spi_gnt_o, dbg_gnt_o);
    end
    tick();
    idle_inputs();
    #1;
    n_chk++; if (wr_count_o !== 16'd16) begin n_fail++; $display("FAIL bp_wr_count got %0d exp 16", wr_count_o); end
  endtask

  task automatic test_hold_abort();
    fetch_enable_i = 1;
    tick();
    n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL abort_enter_hold got %0d exp 2", state_o); end
    for (int k = 2; k <= 14; k++) begin
      tick();
      if (k == 5) begin
        drive_spi(32'h500, 32'h7, 1'b1);
        #1;
        n_chk++; if (spi_gnt_o !== 1'b0 || mem_req_o !== 1'b0) begin
          n_fail++; $display("FAIL hold_blocks got sg=%b req=%b exp 0 0", spi_gnt_o, mem_req_o);
        end
        idle_inputs();
      end
    end
    n_chk++; if (state_o !== 3'd2 || fetch_enable_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_at_cnt3 got state=%0d fe=%b exp 2 0", state_o, fetch_enable_o);
    end
    fetch_enable_i = 0;
    tick();
    n_chk++; if (state_o !== 3'd1 || fetch_enable_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_back_load got state=%0d fe=%b exp 1 0", state_o, fetch_enable_o);
    end
  endtask

  task automatic test_hold_full();
    int n;
    n = 0;
    fetch_enable_i = 1;
    while (n < 40) begin
      tick();
      n++;
      if (fetch_enable_o === 1'b1) break;
    end
    n_chk++; if (n !== 17) begin n_fail++; $display("FAIL hold_latency got %0d exp 17", n); end
    n_chk++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL hold_run_state got %0d exp 3", state_o); end
  endtask

  task automatic test_run_cfg();
    fetch_enable_i = 0;
    tick();
    n_chk++; if (state_o !== 3'd3 || fetch_enable_o !== 1'b1) begin
      n_fail++; $display("FAIL run_sticky got state=%0d fe=%b exp 3 1", state_o, fetch_enable_o);
    end
    drive_spi(32'h1A10_7008, 32'h1234_0000, 1'b1);
    #1;
    n_chk++; if (spi_gnt_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL run_cfg_gnt got sg=%b req=%b exp 1 0", spi_gnt_o, mem_req_o);
    end
    tick();
    drive_spi(32'h600, 32'hBEEF, 1'b1);
    #1;
    n_chk++; if (boot_addr_o !== 32'h0) begin n_fail++; $display("FAIL run_cfg_ignored got %h exp 00000000", boot_addr_o); end
    n_chk++; if (spi_gnt_o !== 1'b1 || mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL run_fwd_gnt got sg=%b req=%b exp 1 1", spi_gnt_o, mem_req_o);
    end
    tick();
    idle_inputs();
    #1;
    n_chk++; if (wr_count_o !== 16'd17) begin n_fail++; $display("FAIL run_wr_count got %0d exp 17", wr_count_o); end
  endtask

  task automatic test_reset_mid_burst();
    drive_dbg(32'h700, 32'h1, 1'b0);
    #1;
    n_chk++; if (dbg_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstb_beat0 got %b exp 1", dbg_gnt_o); end
    tick();
    drive_dbg(32'h704, 32'h2, 1'b0);
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    #1;
    n_chk++; if (state_o !== 3'd0 || fetch_enable_o !== 1'b0 || boot_addr_o !== 32'h0000_8000 || wr_count_o !== 16'd0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rstb_values got state=%0d fe=%b boot=%h cnt=%0d req=%b exp 0 0 00008000 0 0",
                         state_o, fetch_enable_o, boot_addr_o, wr_count_o, mem_req_o);
    end
    drive_spi(32'h800, 32'h3, 1'b0);
    #1;
    n_chk++; if (spi_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstb_owner_none got %b exp 1", spi_gnt_o); end
    tick();
    idle_inputs();
    #1;
    n_chk++; if (state_o !== 3'd1 || wr_count_o !== 16'd1) begin
      n_fail++; $display("FAIL rstb_restart got state=%0d cnt=%0d exp 1 1", state_o, wr_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_spi_burst();
    test_cfg_write();
    test_simultaneous();
    test_backpressure();
    test_hold_abort();
    test_hold_full();
    test_run_cfg();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
